// File: rtl/router_pkg.sv
// Shared port-addressing types and helpers for the 1-in/3-out router.
package router_pkg;

  localparam int NUM_PORTS = 3;

  typedef logic [1:0] port_addr_t;

  localparam port_addr_t PORT0     = 2'd0;
  localparam port_addr_t PORT1     = 2'd1;
  localparam port_addr_t PORT2     = 2'd2;
  localparam port_addr_t PORT_NONE = 2'd3;

  // PORT_NONE maps to no bits set, so writes to it vanish.
  function automatic logic [NUM_PORTS-1:0] onehot(input port_addr_t a);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    case (a)
      PORT0:   oh = 3'b001;
      PORT1:   oh = 3'b010;
      PORT2:   oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-port read-timeout: one-cycle registered soft_reset after TIMEOUT consecutive unread-valid cycles.
// No backpressure; optional saturating pulse counter when ROUTER_SYNC_DROP_CNT_EN is defined.
module router_sync_timer #(
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vld,
  input  logic       rd,
  output logic       soft_reset
`ifdef ROUTER_SYNC_DROP_CNT_EN
  , output logic [7:0] drop_cnt
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soft_reset_q, soft_reset_d;
  logic             stall;

  assign stall = vld & ~rd;

  // Terminal count fires the pulse and restarts, so a stuck FIFO re-arms.
  always_comb begin
    cnt_d        = '0;
    soft_reset_d = 1'b0;
    if (stall) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        soft_reset_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

`ifdef ROUTER_SYNC_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (soft_reset_d && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: rtl/router_sync.sv
// Router FSM <-> output FIFO glue: address latch, 0-latency write/full steering, per-port timeout flush.
// No backpressure of its own; FIFO full is muxed back to the FSM. ROUTER_SYNC_DROP_CNT_EN adds drop_cnt_0..2.
module router_sync
  import router_pkg::*;
#(
  parameter int TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  input  logic       empty_0,
  input  logic       empty_1,
  input  logic       empty_2,
  input  logic       full_0,
  input  logic       full_1,
  input  logic       full_2,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic       vld_out_0,
  output logic       vld_out_1,
  output logic       vld_out_2,
  output logic       soft_reset_0,
  output logic       soft_reset_1,
  output logic       soft_reset_2
`ifdef ROUTER_SYNC_DROP_CNT_EN
  , output logic [7:0] drop_cnt_0
  , output logic [7:0] drop_cnt_1
  , output logic [7:0] drop_cnt_2
`endif
);

  port_addr_t           addr_q, addr_d;
  logic [NUM_PORTS-1:0] vld;
  logic [NUM_PORTS-1:0] rd;
  logic [NUM_PORTS-1:0] sr;

  assign addr_d = detect_add ? port_addr_t'(data_in) : addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= PORT0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Steering reads the registered address, so a same-cycle decode+write uses the old port.
  assign write_enb = write_enb_reg ? onehot(addr_q) : 3'b000;

  always_comb begin
    fifo_full = 1'b0;
    case (addr_q)
      PORT0:   fifo_full = full_0;
      PORT1:   fifo_full = full_1;
      PORT2:   fifo_full = full_2;
      default: fifo_full = 1'b0;
    endcase
  end

  assign vld = {~empty_2, ~empty_1, ~empty_0};
  assign rd  = {read_enb_2, read_enb_1, read_enb_0};

  assign vld_out_0 = vld[0];
  assign vld_out_1 = vld[1];
  assign vld_out_2 = vld[2];

`ifdef ROUTER_SYNC_DROP_CNT_EN
  logic [7:0] drop [NUM_PORTS];
  assign drop_cnt_0 = drop[0];
  assign drop_cnt_1 = drop[1];
  assign drop_cnt_2 = drop[2];
`endif

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timer
    router_sync_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .vld        (vld[g]),
      .rd         (rd[g]),
      .soft_reset (sr[g])
`ifdef ROUTER_SYNC_DROP_CNT_EN
      , .drop_cnt (drop[g])
`endif
    );
  end

  assign soft_reset_0 = sr[0];
  assign soft_reset_1 = sr[1];
  assign soft_reset_2 = sr[2];

endmodule
